bus_timer: RTL and testbench
============================

# bus_timer

Memory-mapped machine timer that sits on the responder side of the CPU's unified memory bus, downstream of the bus arbiter. It decodes the arbiter's shared address, read, write, write-mask and write-value signals. Reads return data in the same cycle and writes take effect on the next clock edge, which matches the arbiter's single-cycle ready assumption. It implements a 64-bit prescaled `mtime` counter, a 64-bit `mtimecmp` compare register and a registered timer interrupt for the core.

## Interface
- `BASE_ADDR`, default 32'h0002_0000: base of the 32-byte register window; the block is selected when `address_in[31:5] == BASE_ADDR[31:5]`.
- `PRESCALE_WIDTH`, default 8: width of the prescale divisor field and of the prescale counter.

- `clk` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `address_in` input 32: byte address from the bus arbiter.
- `read_in` input 1: read strobe. Valid for one cycle per access.
- `write_in` input 1: write strobe. Valid for one cycle per access.
- `write_mask_in` input 4: byte-lane enables; bit i enables bits [8i+7:8i].
- `write_value_in` input 32: write data.
- `read_value_out` output 32: combinational read data. Zero when not selected or `read_in` is low.
- `timer_irq` output 1: registered interrupt, level-sensitive.

## Operation
- `sel` = address match. `offset` = `address_in[4:2]`. Bits [1:0] are ignored.
- Register map:
  - 0x00 `MTIME_LO`, read/write.
  - 0x04 `MTIME_HI`, read/write. Reads return the shadow register.
  - 0x08 `MTIMECMP_LO`, read/write.
  - 0x0C `MTIMECMP_HI`, read/write.
  - 0x10 `CTRL`, read/write: bit0 = enable; bits [8+PRESCALE_WIDTH-1:8] = `div`. All other bits read 0.
  - 0x14 `STATUS`, read-only: bit0 = `timer_irq`.
  - 0x18 and 0x1C read 0; writes to them are ignored.
- Reset values:
  - `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `CTRL` = 0, prescale counter = 0, shadow = 0, `timer_irq` = 0.
- Prescaler:
  - While enable = 1, the prescale counter increments each cycle.
  - When the counter equals `div`, the cycle is a tick and the counter returns to 0.
  - While enable = 0, the counter holds at 0.
  - `div` = 0 gives a tick every cycle.
- On a tick, `mtime` increments by 1 as a full 64-bit value. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes (`sel && write_in`) update only the byte lanes enabled in `write_mask_in`. A mask of 0 is a no-op.
- Any write to `CTRL` (non-zero mask) clears the prescale counter to 0.
- Atomic 64-bit read: a read of `MTIME_LO` captures the current `mtime[63:32]` into the shadow at that clock edge. A read of `MTIME_HI` returns the shadow, never the live high word.
- Interrupt: on each edge, `timer_irq` <= enable && (`mtime` >= `mtimecmp`), unsigned 64-bit compare on the pre-edge register values. The interrupt is cleared only by raising `mtimecmp`, lowering `mtime`, or clearing enable.
- If `read_in` and `write_in` are both asserted, the read returns pre-write data and the write is applied.

## Timing
- Read latency is 0 cycles (combinational). Write latency is 1 edge.
- Simultaneous tick and `MTIME_LO`/`MTIME_HI` write:
  - Enabled bytes take the write data.
  - Un-enabled bytes of the written word keep their pre-edge value.
  - The increment is suppressed for the whole 64-bit counter that cycle.
- Simultaneous tick and `CTRL` write: `mtime` still increments on that tick, and the prescale counter becomes 0.
- `timer_irq` lags its compare condition by exactly 1 cycle.
- `reset` overrides any concurrent write or tick. The cycle after reset, every output and register holds its reset value.

## Test plan
- Reset, then read every offset: `MTIME_LO`/`MTIME_HI` = 0, `MTIMECMP_LO`/`MTIMECMP_HI` = 32'hFFFF_FFFF, `CTRL` = 0, `STATUS` = 0, 0x18 = 0. `timer_irq` = 0.
- Write `CTRL` = 32'h0000_0301 (div = 3, enable), then idle 20 cycles: `MTIME_LO` = 5, with ticks on cycles 4, 8, 12, 16, 20 after the write.
- Write `mtime` = 64'h0000_0000_FFFF_FFFE, enable with div = 0: after 2 ticks `MTIME_LO` = 0. A read of `MTIME_LO` followed by a read of `MTIME_HI` returns 1 even if further ticks occur between the two reads.
- Write `MTIMECMP_HI` = 0 and `MTIMECMP_LO` = 10 with `mtime` = 0, div = 0, enabled: `timer_irq` rises 1 cycle after `mtime` reaches 10. Writing `MTIMECMP_LO` = 100 drops it 1 cycle after that write.
- Write `MTIME_LO` with mask 4'b0010 and data 32'h0000_AB00 while ticking, pre-edge `mtime` = 32'h0000_0010: the result is 32'h0000_AB10 with no increment that cycle.
- Write with `address_in` = `BASE_ADDR` + 32'h40 (not selected): no register changes, `read_value_out` = 0. Asserting `reset` during a counting run gives all reset values on the next cycle.

Source files
------------

// File: rtl/bus_timer.sv
// Memory-mapped machine timer: prescaled 64-bit mtime, 64-bit mtimecmp and a
// registered level interrupt, decoded from the shared arbiter bus.
module bus_timer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0002_0000,
    parameter int          PRESCALE_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        read_in,
    input  logic        write_in,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic [31:0] read_value_out,
    output logic        timer_irq
);

    typedef enum logic [2:0] {
        OFF_MTIME_LO    = 3'd0,
        OFF_MTIME_HI    = 3'd1,
        OFF_MTIMECMP_LO = 3'd2,
        OFF_MTIMECMP_HI = 3'd3,
        OFF_CTRL        = 3'd4,
        OFF_STATUS      = 3'd5,
        OFF_RSVD0       = 3'd6,
        OFF_RSVD1       = 3'd7
    } reg_off_t;

    logic [63:0]               mtime;
    logic [63:0]               mtimecmp;
    logic [31:0]               shadow_hi;
    logic                      ctrl_en;
    logic [PRESCALE_WIDTH-1:0] ctrl_div;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;

    logic        sel;
    reg_off_t    offset;
    logic        wr;
    logic        tick;
    logic [31:0] ctrl_word;
    logic [31:0] ctrl_next;
    logic        unused_addr_lsbs;

    assign sel              = (address_in[31:5] == BASE_ADDR[31:5]);
    assign offset           = reg_off_t'(address_in[4:2]);
    assign wr               = sel && write_in && (write_mask_in != 4'b0000);
    assign tick             = ctrl_en && (pre_cnt == ctrl_div);
    assign unused_addr_lsbs = ^address_in[1:0];

    // Replace only the byte lanes enabled in the mask.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  mask);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) result[8*i +: 8] = new_val[8*i +: 8];
        end
        return result;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        ctrl_word                       = '0;
        ctrl_word[0]                    = ctrl_en;
        ctrl_word[8 +: PRESCALE_WIDTH]  = ctrl_div;
        ctrl_next                       = merge_lanes(ctrl_word, write_value_in, write_mask_in);
    end

    always_comb begin
        read_value_out = '0;
        if (sel && read_in) begin
            case (offset)
                OFF_MTIME_LO:    read_value_out = mtime[31:0];
                OFF_MTIME_HI:    read_value_out = shadow_hi;
                OFF_MTIMECMP_LO: read_value_out = mtimecmp[31:0];
                OFF_MTIMECMP_HI: read_value_out = mtimecmp[63:32];
                OFF_CTRL:        read_value_out = ctrl_word;
                OFF_STATUS:      read_value_out = {31'b0, timer_irq};
                default:         read_value_out = '0;
            endcase
        end
    end

    // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            shadow_hi <= '0;
            ctrl_en   <= 1'b0;
            ctrl_div  <= '0;
            pre_cnt   <= '0;
            timer_irq <= 1'b0;
        end else begin
            timer_irq <= ctrl_en && (mtime >= mtimecmp);

            // Latching the high word on a low-word read makes a LO/HI pair atomic.
            if (sel && read_in && offset == OFF_MTIME_LO)
                shadow_hi <= mtime[63:32];

            // A write to either mtime word suppresses the tick for the whole counter.
            if (wr && offset == OFF_MTIME_LO)
                mtime[31:0] <= merge_lanes(mtime[31:0], write_value_in, write_mask_in);
            else if (wr && offset == OFF_MTIME_HI)
                mtime[63:32] <= merge_lanes(mtime[63:32], write_value_in, write_mask_in);
            else if (tick)
                mtime <= mtime + 64'd1;

            if (wr && offset == OFF_MTIMECMP_LO)
                mtimecmp[31:0] <= merge_lanes(mtimecmp[31:0], write_value_in, write_mask_in);
            if (wr && offset == OFF_MTIMECMP_HI)
                mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], write_value_in, write_mask_in);

            if (wr && offset == OFF_CTRL) begin
                ctrl_en  <= ctrl_next[0];
                ctrl_div <= ctrl_next[8 +: PRESCALE_WIDTH];
                pre_cnt  <= '0;
            end else if (!ctrl_en || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed bus traffic, a per-cycle
// reference model compare, and literal expectations from hand calculation.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address_in;
    logic        read_in;
    logic        write_in;
    logic [3:0]  write_mask_in;
    logic [31:0] write_value_in;
    logic [31:0] read_value_out;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    bus_timer #(.BASE_ADDR(BASE), .PRESCALE_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .address_in     (address_in),
        .read_in        (read_in),
        .write_in       (write_in),
        .write_mask_in  (write_mask_in),
        .write_value_in (write_value_in),
        .read_value_out (read_value_out),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state as the register map describes it.
    logic [63:0] m_time, m_cmp;
    logic [31:0] m_shadow, m_ctrl;
    logic [7:0]  m_div;
    logic        m_en, m_irq, m_tick, m_wr, m_sel;
    logic [2:0]  m_off;
    int unsigned m_phase;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] lanes(input logic [31:0] old_val, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read();
        if (!read_in || address_in[31:5] != BASE[31:5]) return 32'h0;
        case (address_in[4:2])
            3'd0:    return m_time[31:0];
            3'd1:    return m_shadow;
            3'd2:    return m_cmp[31:0];
            3'd3:    return m_cmp[63:32];
            3'd4:    return {16'h0, m_div, 7'h0, m_en};
            3'd5:    return {31'h0, m_irq};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_time   = 64'h0;
            m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
            m_shadow = 32'h0;
            m_en     = 1'b0;
            m_div    = 8'h0;
            m_phase  = 0;
            m_irq    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            m_sel  = (address_in[31:5] == BASE[31:5]);
            m_off  = address_in[4:2];
            m_wr   = m_sel && write_in && (write_mask_in != 4'h0);
            // A tick is every (div+1)-th enabled cycle since the last restart.
            m_tick = m_en && (m_phase == 32'(m_div));
            m_irq  = m_en && (m_time >= m_cmp);
            if (m_sel && read_in && m_off == 3'd0) m_shadow = m_time[63:32];
            m_phase = (m_tick || !m_en) ? 0 : m_phase + 1;
            if (m_wr && m_off == 3'd0)      m_time[31:0]  = lanes(m_time[31:0], write_value_in, write_mask_in);
            else if (m_wr && m_off == 3'd1) m_time[63:32] = lanes(m_time[63:32], write_value_in, write_mask_in);
            else if (m_tick)                m_time        = m_time + 64'd1;
            if (m_wr && m_off == 3'd2) m_cmp[31:0]  = lanes(m_cmp[31:0], write_value_in, write_mask_in);
            if (m_wr && m_off == 3'd3) m_cmp[63:32] = lanes(m_cmp[63:32], write_value_in, write_mask_in);
            if (m_wr && m_off == 3'd4) begin
                m_ctrl  = lanes({16'h0, m_div, 7'h0, m_en}, write_value_in, write_mask_in);
                m_en    = m_ctrl[0];
                m_div   = m_ctrl[15:8];
                m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_read_value", read_value_out, model_read());
            check("model_timer_irq", {31'h0, timer_irq}, {31'h0, m_irq});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wr(input logic [2:0] off, input logic [3:0] mask, input logic [31:0] data);
        address_in     = BASE | {27'h0, off, 2'b00};
        write_in       = 1'b1;
        write_mask_in  = mask;
        write_value_in = data;
        step();
        write_in       = 1'b0;
        write_mask_in  = 4'h0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string name);
        address_in = BASE | {27'h0, off, 2'b00};
        read_in    = 1'b1;
        @(negedge clk);
        check(name, read_value_out, exp);
        step();
        read_in = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        read_in        = 1'b0;
        write_in       = 1'b0;
        write_mask_in  = 4'h0;
        address_in     = 32'h0;
        write_value_in = 32'h0;
        step();
        step();
        reset = 1'b0;

        // Reset values of every offset.
        check("irq_after_reset", {31'h0, timer_irq}, 32'h0);
        rd(3'd0, 32'h0, "rst_mtime_lo");
        rd(3'd1, 32'h0, "rst_mtime_hi");
        rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(3'd4, 32'h0, "rst_ctrl");
        rd(3'd5, 32'h0, "rst_status");
        rd(3'd6, 32'h0, "rst_rsvd18");

        // div = 3: five ticks in 20 cycles.
        wr(3'd4, 4'hF, 32'h0000_0301);
        idle(20);
        rd(3'd0, 32'd5, "prescale_div3");
        rd(3'd4, 32'h0000_0301, "ctrl_readback");
        wr(3'd4, 4'hF, 32'h0);

        // Carry from low to high word, and the atomic high-word shadow.
        wr(3'd1, 4'hF, 32'h0);
        wr(3'd0, 4'hF, 32'hFFFF_FFFE);
        wr(3'd4, 4'hF, 32'h1);
        idle(2);
        rd(3'd0, 32'h0, "carry_lo");
        idle(3);
        rd(3'd1, 32'h1, "shadow_hi");

        // Full 64-bit wrap.
        wr(3'd4, 4'hF, 32'h0);
        wr(3'd1, 4'hF, 32'hFFFF_FFFF);
        wr(3'd0, 4'hF, 32'hFFFF_FFFF);
        wr(3'd4, 4'hF, 32'h1);
        idle(1);
        rd(3'd0, 32'h0, "wrap64_lo");
        rd(3'd1, 32'h0, "wrap64_hi");

        // Interrupt rise one cycle after mtime reaches mtimecmp, fall after raising it.
        wr(3'd4, 4'hF, 32'h0);
        wr(3'd1, 4'hF, 32'h0);
        wr(3'd0, 4'hF, 32'h0);
        wr(3'd3, 4'hF, 32'h0);
        wr(3'd2, 4'hF, 32'd10);
        check("irq_idle", {31'h0, timer_irq}, 32'h0);
        wr(3'd4, 4'hF, 32'h1);
        idle(10);
        check("irq_at_equal", {31'h0, timer_irq}, 32'h0);
        idle(1);
        check("irq_rise", {31'h0, timer_irq}, 32'h1);
        wr(3'd2, 4'hF, 32'd100);
        check("irq_hold_on_write", {31'h0, timer_irq}, 32'h1);
        idle(1);
        check("irq_fall", {31'h0, timer_irq}, 32'h0);

        // Simultaneous read and write returns pre-write data.
        address_in     = BASE | 32'h8;
        read_in        = 1'b1;
        write_in       = 1'b1;
        write_mask_in  = 4'hF;
        write_value_in = 32'd200;
        @(negedge clk);
        check("rw_same_cycle_old", read_value_out, 32'd100);
        step();
        read_in       = 1'b0;
        write_in      = 1'b0;
        write_mask_in = 4'h0;
        rd(3'd2, 32'd200, "rw_same_cycle_new");

        // Byte-lane write during a tick suppresses the increment.
        wr(3'd4, 4'hF, 32'h0);
        wr(3'd1, 4'hF, 32'h0);
        wr(3'd0, 4'hF, 32'h0000_000F);
        wr(3'd4, 4'hF, 32'h1);
        idle(1);
        wr(3'd0, 4'b0010, 32'h0000_AB00);
        rd(3'd0, 32'h0000_AB10, "masked_write");
        wr(3'd4, 4'hF, 32'h1);
        rd(3'd0, 32'h0000_AB12, "ctrl_write_keeps_tick");
        rd(3'd5, 32'h1, "status_irq");

        // Unselected address: no effect, reads zero.
        wr(3'd4, 4'hF, 32'h0);
        wr(3'd0, 4'hF, 32'h0000_1234);
        address_in     = BASE + 32'h40;
        read_in        = 1'b1;
        write_in       = 1'b1;
        write_mask_in  = 4'hF;
        write_value_in = 32'hFFFF_FFFF;
        @(negedge clk);
        check("unsel_read_zero", read_value_out, 32'h0);
        step();
        read_in       = 1'b0;
        write_in      = 1'b0;
        write_mask_in = 4'h0;
        rd(3'd0, 32'h0000_1234, "unsel_no_write");

        // Reset in the middle of a counting run, with a concurrent write.
        wr(3'd4, 4'hF, 32'h0000_0101);
        idle(5);
        reset          = 1'b1;
        address_in     = BASE;
        write_in       = 1'b1;
        write_mask_in  = 4'hF;
        write_value_in = 32'h0000_DEAD;
        step();
        reset         = 1'b0;
        write_in      = 1'b0;
        write_mask_in = 4'h0;
        check("irq_after_midrun_reset", {31'h0, timer_irq}, 32'h0);
        rd(3'd0, 32'h0, "rst2_mtime_lo");
        rd(3'd1, 32'h0, "rst2_mtime_hi");
        rd(3'd2, 32'hFFFF_FFFF, "rst2_cmp_lo");
        rd(3'd3, 32'hFFFF_FFFF, "rst2_cmp_hi");
        rd(3'd4, 32'h0, "rst2_ctrl");
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
